// File: rtl/i2s_rx_deserializer.sv
// Slave-mode Philips I2S receiver: oversamples SCK/WS/SD on clk and emits words on valid/ready.
// Optional macro I2S_RX_FRAME_ERR_EN adds a sticky frame_err flag for short/long words.
module i2s_rx_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        frame_32,
    input  logic        sck,
    input  logic        ws,
    input  logic        sd,
    output logic [31:0] rx_data,
    output logic        rx_ch,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        ovf,
`ifdef I2S_RX_FRAME_ERR_EN
    output logic        frame_err,
`endif
    input  logic        ovf_clr
);

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ws_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_q;
    logic                   sck_prev_q;
    logic                   ws_q;
    logic [5:0]             cnt_q;
    logic [31:0]            shift_q;
    logic [31:0]            rx_data_q;
    logic                   rx_ch_q;
    logic                   rx_valid_q;
    logic                   ovf_q;
`ifdef I2S_RX_FRAME_ERR_EN
    logic                   frame_err_q;
`endif

    logic        sck_s;
    logic        ws_s;
    logic        sd_s;
    logic        sck_rise;
    logic        ws_edge;
    logic [5:0]  w_bits;
    logic [5:0]  bit_pos;
    logic [5:0]  cnt_d;
    logic [31:0] shift_d;
    logic        word_done;
    logic        accept;

    always_comb begin
        sck_s     = sck_sync_q[SYNC_STAGES-1];
        ws_s      = ws_sync_q[SYNC_STAGES-1];
        sd_s      = sd_sync_q[SYNC_STAGES-1];
        sck_rise  = sck_s & ~sck_prev_q;
        ws_edge   = ws_s ^ ws_q;
        w_bits    = frame_32 ? 6'd32 : 6'd16;
        bit_pos   = w_bits - 6'd1 - cnt_q;
        shift_d   = shift_q;
        if (cnt_q < w_bits) begin
            shift_d[bit_pos[4:0]] = sd_s;
        end
        // Bit count saturates at W+1 so long words remain distinguishable from exact ones
        cnt_d     = (cnt_q > w_bits) ? cnt_q : cnt_q + 6'd1;
        word_done = en && sck_rise && ws_edge && (state_q == ST_SHIFT);
        accept    = ~rx_valid_q | rx_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            sck_sync_q  <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            sck_prev_q  <= 1'b0;
            ws_q        <= 1'b0;
            cnt_q       <= 6'd0;
            shift_q     <= 32'd0;
            rx_data_q   <= 32'd0;
            rx_ch_q     <= 1'b0;
            rx_valid_q  <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws};
            sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd};
            sck_prev_q <= sck_s;
            if (sck_rise) begin
                ws_q <= ws_s;
            end

            if (!en) begin
                state_q <= ST_SYNC;
                cnt_q   <= 6'd0;
                shift_q <= 32'd0;
            end else if (sck_rise) begin
                case (state_q)
                    ST_SYNC: begin
                        if (ws_edge) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= 6'd0;
                            shift_q <= 32'd0;
                        end
                    end
                    default: begin
                        if (ws_edge) begin
                            cnt_q   <= 6'd0;
                            shift_q <= 32'd0;
                        end else begin
                            cnt_q   <= cnt_d;
                            shift_q <= shift_d;
                        end
                    end
                endcase
            end

            if (word_done && accept) begin
                rx_data_q  <= shift_d;
                rx_ch_q    <= ws_q;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (word_done && !accept) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end

`ifdef I2S_RX_FRAME_ERR_EN
            if (word_done && (cnt_d != w_bits)) begin
                frame_err_q <= 1'b1;
            end else if (ovf_clr) begin
                frame_err_q <= 1'b0;
            end
`endif
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_ch    = rx_ch_q;
    assign rx_valid = rx_valid_q;
    assign ovf      = ovf_q;
`ifdef I2S_RX_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Scoreboard bench for i2s_rx_deserializer: directed I2S streams, monitor checks each transfer.
module tb_i2s_rx_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        frame_32;
    logic        sck;
    logic        ws;
    logic        sd;
    logic [31:0] rx_data;
    logic        rx_ch;
    logic        rx_valid;
    logic        rx_ready;
    logic        ovf;
    logic        ovf_clr;
`ifdef I2S_RX_FRAME_ERR_EN
    logic        frame_err;
`endif

    i2s_rx_deserializer #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .frame_32 (frame_32),
        .sck      (sck),
        .ws       (ws),
        .sd       (sd),
        .rx_data  (rx_data),
        .rx_ch    (rx_ch),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .ovf      (ovf),
`ifdef I2S_RX_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endfunction

    // Transfers happen on the posedge following a negedge where valid && ready are seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got ch=%0d data=%h, expected no word", rx_ch, rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", rx_data, e.data);
                    check("word_ch", {31'd0, rx_ch}, {31'd0, e.ch});
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(logic w, logic d);
        sck = 1'b0; ws = w; sd = d;
        tick(4);
        sck = 1'b1;
        tick(4);
    endtask

    // Word of n bits on channel ch, MSB first; ws flips on the last bit (Philips one-bit delay).
    task automatic send_word(logic ch, logic [31:0] data, int n, int w);
        for (int i = 0; i < n; i++)
            send_bit((i == n - 1) ? ~ch : ch, (i < w) ? data[w-1-i] : 1'b0);
    endtask

    task automatic expect_word(logic ch, logic [31:0] d);
        exp_t e;
        e.ch = ch; e.data = d;
        exp_q.push_back(e);
    endtask

    // Set word size with en low, then give a discarded partial word ending in a ws edge to the left channel.
    task automatic restart(logic f);
        en = 1'b0; frame_32 = f;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        en = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; frame_32 = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        rx_ready = 1'b1; ovf_clr = 1'b0;
        tick(3);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_data", rx_data, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
`ifdef I2S_RX_FRAME_ERR_EN
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
`endif
        rst = 1'b0;
        tick(2);

        // 1: 32-bit left/right
        restart(1'b1);
        expect_word(1'b0, 32'hA5A50F0F);
        send_word(1'b0, 32'hA5A50F0F, 32, 32);
        expect_word(1'b1, 32'h12345678);
        send_word(1'b1, 32'h12345678, 32, 32);
        drain("t1_drain");
        tick(20);
        check("t1_ovf", {31'd0, ovf}, 32'd0);
`ifdef I2S_RX_FRAME_ERR_EN
        check("t1_frame_err", {31'd0, frame_err}, 32'd0);
`endif

        // 2: 16-bit mode
        restart(1'b0);
        expect_word(1'b0, 32'h0000BEEF);
        send_word(1'b0, 32'h0000BEEF, 16, 16);
        expect_word(1'b1, 32'h00008001);
        send_word(1'b1, 32'h00008001, 16, 16);
        drain("t2_drain");

        // 3: overrun while stalled
        rx_ready = 1'b0;
        restart(1'b1);
        expect_word(1'b0, 32'h11111111);
        send_word(1'b0, 32'h11111111, 32, 32);
        send_word(1'b1, 32'h22222222, 32, 32);
        check("t3_valid_held", {31'd0, rx_valid}, 32'd1);
        check("t3_data_held", rx_data, 32'h11111111);
        check("t3_ovf_set", {31'd0, ovf}, 32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        check("t3_valid_after_xfer", {31'd0, rx_valid}, 32'd0);
        check("t3_data_after_xfer", rx_data, 32'h11111111);
        check("t3_ovf_still_set", {31'd0, ovf}, 32'd1);
        pulse_clr();
        check("t3_ovf_cleared", {31'd0, ovf}, 32'd0);
        drain("t3_drain");

        // 4: short word, 24 ones in 32-bit mode
        rx_ready = 1'b1;
        restart(1'b1);
        expect_word(1'b0, 32'hFFFFFF00);
        send_word(1'b0, 32'hFFFFFFFF, 24, 32);
        drain("t4_drain");
`ifdef I2S_RX_FRAME_ERR_EN
        check("t4_frame_err_set", {31'd0, frame_err}, 32'd1);
        pulse_clr();
        check("t4_frame_err_cleared", {31'd0, frame_err}, 32'd0);
`endif

        // 5: reset mid-word
        restart(1'b1);
        for (int i = 0; i < 10; i++) send_bit(1'b0, i[0]);
        rst = 1'b1;
        tick(1);
        check("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("t5_rst_data", rx_data, 32'd0);
        check("t5_rst_ovf", {31'd0, ovf}, 32'd0);
        tick(2);
        rst = 1'b0;
        send_word(1'b0, 32'hFFFFFFFF, 22, 32);
        expect_word(1'b1, 32'hCAFEF00D);
        send_word(1'b1, 32'hCAFEF00D, 32, 32);
        expect_word(1'b0, 32'h0BADBEEF);
        send_word(1'b0, 32'h0BADBEEF, 32, 32);
        drain("t5_drain");

        // 6: en low mid-word with a pending word
        rx_ready = 1'b0;
        restart(1'b1);
        expect_word(1'b0, 32'h13579BDF);
        send_word(1'b0, 32'h13579BDF, 32, 32);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, i[0]);
        check("t6_pending_valid", {31'd0, rx_valid}, 32'd1);
        check("t6_pending_data", rx_data, 32'h13579BDF);
        check("t6_pending_ch", {31'd0, rx_ch}, 32'd0);
        check("t6_ovf", {31'd0, ovf}, 32'd0);
        rx_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        expect_word(1'b0, 32'h2468ACE0);
        send_word(1'b0, 32'h2468ACE0, 32, 32);
        drain("t6_drain");
        tick(20);
        check("t6_ovf_end", {31'd0, ovf}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
